// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake status and the machine word.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/dp_types_pkg.sv
// Datapath-side types: memory arbiter states, grant encodings and counter sizing.
package dp_types_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } arb_state_t;

    localparam logic [1:0] GNT_NONE  = 2'b00;
    localparam logic [1:0] GNT_INSTR = 2'b01;
    localparam logic [1:0] GNT_DATA  = 2'b10;

    // A limit of 0 still needs a 1-bit register.
    function automatic int dstreak_w(input int max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/arb_fair_cnt.sv
// Saturating count of consecutive data grants taken while an instruction fetch waits.
module arb_fair_cnt
    import dp_types_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic inc,
    output logic at_limit
);

    localparam int W = dstreak_w(MAX);
    localparam logic [W-1:0] LIMIT = W'(MAX);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (inc && !at_limit)
            cnt <= cnt + W'(1);
    end

    assign at_limit = (cnt >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, data first
// with a fairness limit so a waiting fetch is eventually served.
module mem_arbiter
    import cpu_types_pkg::*;
    import dp_types_pkg::*;
#(
    parameter int MAX_DSTREAK = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  ramstate_t         ramstate,
    output logic [1:0]        gnt
);

    // Handshake: a requester holds its enable (the "valid") and its address/data
    // stable; its wait (inverted "ready") drops for exactly one cycle, the cycle
    // in which the RAM reports ACCESS, and read data is only meaningful then.
    // Dropping the enable while granted abandons the transfer without a pulse.

    arb_state_t state, next_state;
    logic       dreq;
    logic       cnt_clear, cnt_inc, at_limit;

    assign dreq = dREN | dWEN;

    arb_fair_cnt #(.MAX(MAX_DSTREAK)) u_fair_cnt (
        .CLK      (CLK),
        .nRST     (nRST),
        .clear    (cnt_clear),
        .inc      (cnt_inc),
        .at_limit (at_limit)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (dreq && (!iREN || !at_limit)) begin
                    next_state = GNT_D;
                    cnt_inc    = iREN;
                    cnt_clear  = !iREN;
                end else if (iREN) begin
                    next_state = GNT_I;
                    cnt_clear  = 1'b1;
                end
            end
            GNT_I:   if (!iREN || ramstate == ACCESS) next_state = IDLE;
            GNT_D:   if (!dreq || ramstate == ACCESS) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        gnt      = GNT_NONE;
        case (state)
            GNT_I: begin
                gnt     = GNT_INSTR;
                ramaddr = iaddr;
                if (iREN) begin
                    ramREN = 1'b1;
                    if (ramstate == ACCESS) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end
            end
            GNT_D: begin
                gnt      = GNT_DATA;
                ramaddr  = daddr;
                ramstore = dstore;
                if (dreq) begin
                    // A write wins when both enables are raised.
                    ramWEN = dWEN;
                    ramREN = !dWEN;
                    if (ramstate == ACCESS) begin
                        dwait = 1'b0;
                        dload = ramload;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
